// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle CPU control sequencer: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives the datapath strobes, counts
// retired instructions and parks in HALT on ecall, illegal opcode or a data
// memory access that never completes.
module cpu_stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             reg_write,
  output logic             wb_sel_mem,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired,
  output logic             retire_pulse
);

  // Wide enough to hold MEM_TIMEOUT itself on the final timed-out cycle.
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAluR,
    ClsAluI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsEcall,
    ClsIllegal
  } cls_e;

  localparam logic [1:0] CauseNone    = 2'd0;
  localparam logic [1:0] CauseEcall   = 2'd1;
  localparam logic [1:0] CauseIllegal = 2'd2;
  localparam logic [1:0] CauseTimeout = 2'd3;

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d, dec_cls;
  logic [1:0]         cause_q, cause_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q;

  // Opcode decode; only consumed while in DECODE.
  always_comb begin
    unique case (opcode)
      7'b0110011: dec_cls = ClsAluR;
      7'b0010011: dec_cls = ClsAluI;
      7'b0000011: dec_cls = ClsLoad;
      7'b0100011: dec_cls = ClsStore;
      7'b1100011: dec_cls = ClsBranch;
      7'b1110011: dec_cls = ClsEcall;
      default:    dec_cls = ClsIllegal;
    endcase
  end

  // Next-state and strobe generation from state and registered class.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cause_d       = cause_q;
    wait_d        = wait_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    reg_write     = 1'b0;
    wb_sel_mem    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    retire_pulse  = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_cls == ClsEcall) begin
          state_d = StHalt;
          cause_d = CauseEcall;
        end else if (dec_cls == ClsIllegal) begin
          state_d = StHalt;
          cause_d = CauseIllegal;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        case (cls_q)
          ClsAluR, ClsAluI: state_d = StWriteback;
          ClsLoad, ClsStore: begin
            state_d = StMemory;
            wait_d  = '0;
          end
          ClsBranch: begin
            pc_write      = 1'b1;
            pc_sel_branch = branch_taken;
            retire_pulse  = 1'b1;
            state_d       = StFetch;
          end
          default: begin
            // Halting classes never reach EXECUTE; treat a corrupt class as illegal.
            state_d = StHalt;
            cause_d = CauseIllegal;
          end
        endcase
      end
      StMemory: begin
        mem_read  = (cls_q == ClsLoad);
        mem_write = (cls_q == ClsStore);
        if (mem_ready) begin
          if (cls_q == ClsLoad) begin
            state_d = StWriteback;
          end else begin
            pc_write     = 1'b1;
            retire_pulse = 1'b1;
            state_d      = StFetch;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          // This stall makes MEM_TIMEOUT consecutive not-ready cycles: abort.
          if (wait_q == WaitW'(MEM_TIMEOUT - 1)) begin
            state_d = StHalt;
            cause_d = CauseTimeout;
          end
        end
      end
      StWriteback: begin
        reg_write    = 1'b1;
        wb_sel_mem   = (cls_q == ClsLoad);
        pc_write     = 1'b1;
        retire_pulse = 1'b1;
        state_d      = StFetch;
      end
      StHalt: begin
        if (resume) begin
          state_d = StFetch;
          cause_d = CauseNone;
        end
      end
      default: begin
        // Unused encodings 6-7.
        state_d = StHalt;
        cause_d = CauseIllegal;
      end
    endcase
  end

  // State, class, cause, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsAluR;
      cause_q   <= CauseNone;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
      if (retire_pulse) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  assign state      = state_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule
